// File: rtl/clkspec_arbtst_server_pkg.sv
//------------------------------------------------------------------
// clkspec_arbtst_pkg - shared state encodings and defaults. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

package clkspec_arbtst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPND = 2'd1,
    ST_RSLT = 2'd2
  } state_t;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_NCLIENT = 2;
  localparam int DEF_CNTW    = 8;

endpackage

`default_nettype wire

// File: rtl/clkspec_arbtst_server_if.sv
//------------------------------------------------------------------
// clkspec_arbtst_server_if - client-side bus of the adder server. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

interface clkspec_arbtst_server_if #(
  parameter int WIDTH   = 4,
  parameter int NCLIENT = 2,
  parameter int CNTW    = 8
);

  logic [NCLIENT-1:0]       req;
  logic [NCLIENT*WIDTH-1:0] a_in;
  logic [NCLIENT*WIDTH-1:0] b_in;
  logic [NCLIENT-1:0]       gnt;
  logic [WIDTH-1:0]         y_out;
  logic                     y_valid;
  logic                     carry;
  logic                     busy;
  logic [CNTW-1:0]          served_cnt;

  modport master (
    output req, a_in, b_in,
    input  gnt, y_out, y_valid, carry, busy, served_cnt
  );

  modport slave (
    input  req, a_in, b_in,
    output gnt, y_out, y_valid, carry, busy, served_cnt
  );

endinterface

`default_nettype wire

// File: rtl/clkspec_arbtst_server_rr_arbiter_n.sv
//------------------------------------------------------------------
// rr_arbiter_n - combinational round-robin pick after last_i. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module rr_arbiter_n #(
  parameter int N = 2
) (
  input  logic [N-1:0]                          eff_i,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0]  last_i,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]  winner_o,
  output logic                                  valid_o
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;

  // Scan farthest-first so the nearest set bit after last_i wins.
  always_comb begin : p_scan
    int idx;
    idx      = 0;
    winner_o = '0;
    valid_o  = 1'b0;
    for (int i = N; i >= 1; i--) begin
      idx = (int'(last_i) + i) % N;
      if (eff_i[LW'(idx)]) begin
        winner_o = LW'(idx);
        valid_o  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/clkspec_arbtst_server.sv
//------------------------------------------------------------------
// clkspec_arbtst_server - round-robin shared adder server. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module clkspec_arbtst_server
  import clkspec_arbtst_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NCLIENT = DEF_NCLIENT,
  parameter int CNTW    = DEF_CNTW
) (
  input  logic                    clk,
  input  logic                    reset,
  clkspec_arbtst_server_if.slave  bus
);

  localparam int LW = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;

  state_t               state_q;
  logic [NCLIENT-1:0]   pend_q;
  logic [NCLIENT-1:0]   gnt_q;
  logic [LW-1:0]        owner_q;
  logic [LW-1:0]        last_q;
  logic [WIDTH-1:0]     y_q;
  logic                 carry_q;
  logic                 yv_q;
  logic [CNTW-1:0]      cnt_q;

  logic [NCLIENT-1:0]   eff;
  logic [NCLIENT-1:0]   win_oh;
  logic [LW-1:0]        win_idx;
  logic                 win_vld;
  logic                 grant_now;
  logic [NCLIENT-1:0]   pend_d;
  logic [WIDTH-1:0]     a_sel;
  logic [WIDTH-1:0]     b_sel;
  logic [WIDTH:0]       sum_d;

  rr_arbiter_n #(
    .N (NCLIENT)
  ) u_arb (
    .eff_i    (eff),
    .last_i   (last_q),
    .winner_o (win_idx),
    .valid_o  (win_vld)
  );

  always_comb begin
    eff       = pend_q | bus.req;
    win_oh    = NCLIENT'(1) << win_idx;
    grant_now = win_vld && ((state_q == ST_IDLE) || (state_q == ST_RSLT));
    pend_d    = eff & ~(grant_now ? win_oh : '0);
    a_sel     = bus.a_in[int'(owner_q)*WIDTH +: WIDTH];
    b_sel     = bus.b_in[int'(owner_q)*WIDTH +: WIDTH];
    sum_d     = {1'b0, a_sel} + {1'b0, b_sel};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= LW'(NCLIENT-1);
      y_q     <= '0;
      carry_q <= 1'b0;
      yv_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pend_q <= pend_d;
      yv_q   <= 1'b0;
      case (state_q)
        ST_IDLE, ST_RSLT: begin
          if ((state_q == ST_RSLT) && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
          end
          // From RSLT a new winner is taken directly: one op per two cycles.
          if (win_vld) begin
            gnt_q   <= win_oh;
            owner_q <= win_idx;
            last_q  <= win_idx;
            state_q <= ST_OPND;
          end else begin
            gnt_q   <= '0;
            state_q <= ST_IDLE;
          end
        end
        ST_OPND: begin
          y_q     <= sum_d[WIDTH-1:0];
          carry_q <= sum_d[WIDTH];
          yv_q    <= 1'b1;
          state_q <= ST_RSLT;
        end
        default: begin
          gnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.y_out      = y_q;
  assign bus.y_valid    = yv_q;
  assign bus.carry      = carry_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.served_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_clkspec_arbtst_server.sv
//------------------------------------------------------------------
// tb_clkspec_arbtst_server - random + directed bench with reference model. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module tb_clkspec_arbtst_server;

  localparam int W = 4;
  localparam int N = 2;
  localparam int C = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  clkspec_arbtst_server_if #(.WIDTH(W), .NCLIENT(N), .CNTW(C)) bus ();

  clkspec_arbtst_server #(.WIDTH(W), .NCLIENT(N), .CNTW(C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference: set of waiting clients, rotating priority, and how many
  // cycles of the current grant remain (2 = operand cycle, 1 = result cycle).
  bit m_pend [N];
  int m_last   = N-1;
  int m_owner  = 0;
  int m_rem    = 0;
  int m_served = 0;
  int m_y      = 0;
  int m_c      = 0;
  int m_v      = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rstn, input logic [N-1:0] r,
                            input logic [N*W-1:0] a, input logic [N*W-1:0] b);
    int s;
    if (!rstn) begin
      for (int k = 0; k < N; k++) m_pend[k] = 1'b0;
      m_last = N-1; m_owner = 0; m_rem = 0; m_served = 0;
      m_y = 0; m_c = 0; m_v = 0;
    end else begin
      for (int k = 0; k < N; k++) if (r[k]) m_pend[k] = 1'b1;
      if (m_rem == 2) begin
        s   = int'(a[m_owner*W +: W]) + int'(b[m_owner*W +: W]);
        m_y = s % (1 << W);
        m_c = s / (1 << W);
        m_v = 1;
        m_rem = 1;
      end else begin
        if (m_rem == 1) begin
          if (m_served < (1 << C) - 1) m_served++;
          m_v = 0;
        end
        m_rem = 0;
        for (int j = 1; j <= N; j++) begin
          int k;
          k = (m_last + j) % N;
          if (m_pend[k]) begin
            m_owner = k; m_last = k; m_pend[k] = 1'b0; m_rem = 2;
            break;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] eg;
    eg = (m_rem != 0) ? (N'(1) << m_owner) : '0;
    chk("gnt",        64'(bus.gnt),        64'(eg));
    chk("y_out",      64'(bus.y_out),      64'(m_y));
    chk("y_valid",    64'(bus.y_valid),    64'(m_v));
    chk("carry",      64'(bus.carry),      64'(m_c));
    chk("busy",       64'(bus.busy),       64'(m_rem != 0));
    chk("served_cnt", 64'(bus.served_cnt), 64'(m_served));
  endtask

  task automatic step(input logic rstn, input logic [N-1:0] r,
                      input logic [N*W-1:0] a, input logic [N*W-1:0] b);
    reset = rstn; bus.req = r; bus.a_in = a; bus.b_in = b;
    @(posedge clk);
    model_edge(rstn, r, a, b);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  function automatic logic [N*W-1:0] rnd();
    return (N*W)'($urandom);
  endfunction

  initial begin
    logic [N-1:0] r, prev_r;
    logic rs;
    reset = 1'b0; bus.req = '0; bus.a_in = '0; bus.b_in = '0;
    @(negedge clk);
    step(1'b0, '0, '0, '0);
    step(1'b0, '0, '0, '0);

    // Single uncontended request: 3 + 4
    step(1'b1, 2'b01, rnd(), rnd());
    chk("t1_gnt_t1", 64'(bus.gnt), 64'(2'b01));
    step(1'b1, 2'b00, {W'($urandom), W'(3)}, {W'($urandom), W'(4)});
    chk("t1_y", 64'(bus.y_out), 64'd7);
    chk("t1_valid", 64'(bus.y_valid), 64'd1);
    step(1'b1, 2'b00, rnd(), rnd());
    chk("t1_cnt", 64'(bus.served_cnt), 64'd1);
    chk("t1_idle", 64'(bus.busy), 64'd0);

    // Overflow: 9 + 9 wraps to 2 with carry, and the result holds
    step(1'b1, 2'b01, rnd(), rnd());
    step(1'b1, 2'b00, {W'($urandom), W'(9)}, {W'($urandom), W'(9)});
    chk("ovf_y", 64'(bus.y_out), 64'd2);
    chk("ovf_carry", 64'(bus.carry), 64'd1);
    step(1'b1, 2'b00, rnd(), rnd());
    step(1'b1, 2'b00, rnd(), rnd());
    chk("ovf_hold", 64'(bus.y_out), 64'd2);

    // Simultaneous requests from reset, then a busy-window re-request
    step(1'b0, '0, '0, '0);
    step(1'b1, 2'b11, rnd(), rnd());
    chk("sim_first", 64'(bus.gnt), 64'(2'b01));
    step(1'b1, 2'b00, rnd(), rnd());
    step(1'b1, 2'b00, rnd(), rnd());
    chk("sim_second", 64'(bus.gnt), 64'(2'b10));
    step(1'b1, 2'b01, rnd(), rnd());
    step(1'b1, 2'b00, rnd(), rnd());
    for (int i = 0; i < 4; i++) step(1'b1, 2'b00, rnd(), rnd());

    // Reset during the operand cycle aborts the operation
    step(1'b1, 2'b01, rnd(), rnd());
    step(1'b0, 2'b00, rnd(), rnd());
    chk("rst_gnt", 64'(bus.gnt), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    step(1'b1, 2'b00, rnd(), rnd());
    chk("rst_nores", 64'(bus.y_valid), 64'd0);

    // Random traffic with occasional resets
    prev_r = '0;
    for (int i = 0; i < 2000; i++) begin
      r  = N'($urandom) & ~prev_r;
      if ($urandom_range(0, 2) == 0) r = '0;
      rs = ($urandom_range(0, 99) != 0);
      step(rs, r, rnd(), rnd());
      prev_r = r;
    end

    // Saturation of the served counter
    step(1'b0, '0, '0, '0);
    for (int i = 0; i < 520; i++) begin
      step(1'b1, (i % 2 == 0) ? 2'b01 : 2'b00, rnd(), rnd());
    end
    step(1'b1, 2'b00, rnd(), rnd());
    chk("sat_cnt", 64'(bus.served_cnt), 64'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
